// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt gateway: per-source state encoding
// and the ID conventions used on the claim/complete buses.
package interrupt_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PENDING    = 2'd1,
      IN_SERVICE = 2'd2
   } gateway_state_t;

   // Width of the claim/complete ID buses (matches the resolver's ID output).
   localparam int ID_WIDTH = 32;

   // ID value meaning "no interrupt"; real source IDs start at 1.
   localparam int NO_INTERRUPT_ID = 0;

endpackage : interrupt_pkg

// File: rtl/interrupt_gateway_cell.sv
// One interrupt source: IDLE/PENDING/IN_SERVICE state, the previous input
// sample for rising-edge detection, and a single-bit latch that remembers an
// edge arriving while the handler is still in service.
module interrupt_gateway_cell
   import interrupt_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sample,
   input  logic mode,
   input  logic enable,
   input  logic claim_hit,
   input  logic complete_hit,
   output logic pending,
   output logic in_service,
   output logic claim_ok,
   output logic complete_ok
);

   gateway_state_t state_r;
   gateway_state_t state_n;
   logic           edge_latch_r;
   logic           edge_latch_n;
   logic           prev_sample_r;
   logic           trigger_s;
   logic           edge_trigger_s;

   // Trigger detection: level-high in level mode, rising edge in edge mode.
   always_comb begin
      if (mode) begin
         trigger_s = sample & ~prev_sample_r;
      end else begin
         trigger_s = sample;
      end
      edge_trigger_s = mode & trigger_s & enable;
   end

   // Next-state logic; a disabled source never records a trigger.
   always_comb begin
      state_n      = state_r;
      edge_latch_n = edge_latch_r;
      case (state_r)
         IDLE: begin
            if (trigger_s && enable) begin
               state_n = PENDING;
            end else begin
               state_n = IDLE;
            end
         end
         PENDING: begin
            // Further edges coalesce into the one pending request.
            if (claim_hit) begin
               state_n = IN_SERVICE;
            end else begin
               state_n = PENDING;
            end
         end
         IN_SERVICE: begin
            if (complete_hit) begin
               // An edge seen during service (or right now) re-arms directly;
               // a level source still high re-triggers from IDLE next cycle.
               if (edge_latch_r || edge_trigger_s) begin
                  state_n = PENDING;
               end else begin
                  state_n = IDLE;
               end
               edge_latch_n = 1'b0;
            end else if (edge_trigger_s) begin
               edge_latch_n = 1'b1;
            end else begin
               edge_latch_n = edge_latch_r;
            end
         end
         default: begin
            state_n      = IDLE;
            edge_latch_n = 1'b0;
         end
      endcase
   end

   // State, edge latch and previous sample registers (prev_sample tracks every cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         edge_latch_r  <= 1'b0;
         prev_sample_r <= 1'b0;
      end else begin
         state_r       <= state_n;
         edge_latch_r  <= edge_latch_n;
         prev_sample_r <= sample;
      end
   end

   // Enable only masks the visible pending bit; the stored state is kept.
   assign pending     = (state_r == PENDING) & enable;
   assign in_service  = (state_r == IN_SERVICE);
   assign claim_ok    = (state_r == PENDING);
   assign complete_ok = (state_r == IN_SERVICE);

endmodule : interrupt_gateway_cell

// File: rtl/interrupt_gateway.sv
// Interrupt gateway: turns raw peripheral lines into the resolver's pending
// vector and tracks claim/complete per source. IDs are 1-based (0 = none).
// Optional build macro INTERRUPT_GATEWAY_SYNC_EN inserts a 2-flop
// synchronizer on every request line (trigger-to-pending latency 3 cycles).
module interrupt_gateway #(
   parameter int N_INTERRUPTS = 32,
   parameter int ID_WIDTH     = interrupt_pkg::ID_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_INTERRUPTS-1:0] interrupt_requests,
   input  logic [N_INTERRUPTS-1:0] edge_triggered,
   input  logic [N_INTERRUPTS-1:0] interrupt_enable,
   input  logic                    claim_req,
   input  logic [ID_WIDTH-1:0]     claim_id,
   input  logic                    complete_req,
   input  logic [ID_WIDTH-1:0]     complete_id,
   output logic [N_INTERRUPTS-1:0] pending_interrupts,
   output logic [N_INTERRUPTS-1:0] in_service,
   output logic                    claim_err,
   output logic                    complete_err
);

   logic [N_INTERRUPTS-1:0] sample_s;
   logic [N_INTERRUPTS-1:0] claim_hit_s;
   logic [N_INTERRUPTS-1:0] complete_hit_s;
   logic [N_INTERRUPTS-1:0] claim_ok_s;
   logic [N_INTERRUPTS-1:0] complete_ok_s;
   logic                    claim_legal_s;
   logic                    complete_legal_s;

`ifdef INTERRUPT_GATEWAY_SYNC_EN
   logic [N_INTERRUPTS-1:0] sync1_r;
   logic [N_INTERRUPTS-1:0] sync2_r;

   // Two-stage synchronizer for asynchronous peripheral lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= interrupt_requests;
         sync2_r <= sync1_r;
      end
   end

   assign sample_s = sync2_r;
`else
   // Lines are already synchronous to clk.
   assign sample_s = interrupt_requests;
`endif

   // Full-width ID decode: upper ID bits must match too, so no aliasing.
   for (genvar k = 0; k < N_INTERRUPTS; k++) begin : g_src
      assign claim_hit_s[k]    = claim_req    && (claim_id    == ID_WIDTH'(k + 1));
      assign complete_hit_s[k] = complete_req && (complete_id == ID_WIDTH'(k + 1));

      interrupt_gateway_cell u_cell (
         .clk          (clk),
         .rst          (rst),
         .sample       (sample_s[k]),
         .mode         (edge_triggered[k]),
         .enable       (interrupt_enable[k]),
         .claim_hit    (claim_hit_s[k]),
         .complete_hit (complete_hit_s[k]),
         .pending      (pending_interrupts[k]),
         .in_service   (in_service[k]),
         .claim_ok     (claim_ok_s[k]),
         .complete_ok  (complete_ok_s[k])
      );
   end

   // A request is legal only if it names a real source in the right state;
   // ID 0 and out-of-range IDs never produce a hit.
   assign claim_legal_s    = (claim_id != ID_WIDTH'(interrupt_pkg::NO_INTERRUPT_ID))
                             && (|(claim_hit_s & claim_ok_s));
   assign complete_legal_s = (complete_id != ID_WIDTH'(interrupt_pkg::NO_INTERRUPT_ID))
                             && (|(complete_hit_s & complete_ok_s));

   // One-cycle error pulses, registered the cycle after an illegal strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         claim_err    <= 1'b0;
         complete_err <= 1'b0;
      end else begin
         claim_err    <= claim_req    & ~claim_legal_s;
         complete_err <= complete_req & ~complete_legal_s;
      end
   end

endmodule : interrupt_gateway
